spi_bus_arbiter: RTL and testbench

//  Shares one SPI bus between NUM_CLIENTS requesters using round-robin arbitration.

---
 rtl/spi_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one mode-0 SPI master among NUM_CLIENTS requesters.
// Optional per-client bus lock is compiled in with `define SPI_ARB_LOCK_EN.
module spi_bus_arbiter #(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned GUARD_TICKS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    output logic                          presc_rst,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        lock,
    input  logic [NUM_CLIENTS*DATA_W-1:0] tx_data,
    output logic [NUM_CLIENTS-1:0]        gnt,
    output logic [NUM_CLIENTS-1:0]        done,
    output logic [DATA_W-1:0]             rx_data,
    output logic [NUM_CLIENTS-1:0]        cs_n,
    output logic                          sclk,
    output logic                          mosi,
    input  logic                          miso
);
    localparam int unsigned IDX_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned SHIFT_TICKS = 2 * DATA_W;
    localparam int unsigned CNT_MAX     = (GUARD_TICKS > SHIFT_TICKS + 1) ? GUARD_TICKS
                                                                          : SHIFT_TICKS + 1;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GUARD = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_CLIENTS-1:0]   gnt_q, gnt_d;
    logic [NUM_CLIENTS-1:0]   cs_n_q, cs_n_d;
    logic [NUM_CLIENTS-1:0]   done_q, done_d;
    logic [DATA_W-1:0]        rx_data_q, rx_data_d;
    logic [DATA_W-1:0]        shreg_q, shreg_d;
    logic                     miso_bit_q, miso_bit_d;
    logic                     sclk_q, sclk_d;
    logic                     mosi_q, mosi_d;
    logic                     presc_rst_q, presc_rst_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
`ifdef SPI_ARB_LOCK_EN
    logic                     held_q, held_d;
`else
    logic                     unused_lock;
    assign unused_lock = ^lock;
`endif

    logic                     win_found_c;
    logic [IDX_W-1:0]         win_idx_c;
    logic [DATA_W-1:0]        win_word_c;
    logic [DATA_W-1:0]        cur_word_c;
    logic [DATA_W-1:0]        shift_word_c;
    logic [IDX_W-1:0]         next_ptr_c;
    logic                     reload_c;
    logic                     release_c;

    // First requester at or after the round-robin pointer
    always_comb begin
        int unsigned j;
        win_found_c = 1'b0;
        win_idx_c   = '0;
        j           = 0;
        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
            j = 32'(ptr_q) + k;
            if (j >= NUM_CLIENTS) begin
                j = j - NUM_CLIENTS;
            end
            if (!win_found_c && req[IDX_W'(j)]) begin
                win_found_c = 1'b1;
                win_idx_c   = IDX_W'(j);
            end
        end
    end

    assign win_word_c   = tx_data[32'(win_idx_c) * DATA_W +: DATA_W];
    assign cur_word_c   = tx_data[32'(idx_q) * DATA_W +: DATA_W];
    assign shift_word_c = {shreg_q[DATA_W-2:0], miso_bit_q};
    assign next_ptr_c   = (32'(idx_q) == NUM_CLIENTS - 1) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        gnt_d       = gnt_q;
        cs_n_d      = cs_n_q;
        done_d      = '0;
        rx_data_d   = rx_data_q;
        shreg_d     = shreg_q;
        miso_bit_d  = miso_bit_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        presc_rst_d = presc_rst_q;
        cnt_d       = cnt_q;
        reload_c    = 1'b0;
        release_c   = 1'b0;
`ifdef SPI_ARB_LOCK_EN
        held_d      = held_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    idx_d            = win_idx_c;
                    gnt_d            = '0;
                    gnt_d[win_idx_c] = 1'b1;
                    cs_n_d           = '1;
                    cs_n_d[win_idx_c] = 1'b0;
                    shreg_d          = win_word_c;
                    mosi_d           = win_word_c[DATA_W-1];
                    presc_rst_d      = 1'b0;
                    cnt_d            = '0;
                    state_d          = SETUP;
                end
            end
            SETUP: begin
                // One idle tick gives cs_n-to-sclk setup time
                if (tick) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!sclk_q) begin
                        sclk_d     = 1'b1;
                        miso_bit_d = miso;
                    end else begin
                        sclk_d  = 1'b0;
                        shreg_d = shift_word_c;
                        mosi_d  = shift_word_c[DATA_W-1];
                        if (cnt_q == CNT_W'(SHIFT_TICKS - 1)) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
`ifdef SPI_ARB_LOCK_EN
                if (!held_q) begin
                    if (tick) begin
                        done_d    = gnt_q;
                        rx_data_d = shreg_q;
                        if (lock[idx_q]) begin
                            if (req[idx_q]) begin
                                reload_c = 1'b1;
                            end else begin
                                held_d = 1'b1;
                            end
                        end else begin
                            release_c = 1'b1;
                        end
                    end
                end else if (req[idx_q]) begin
                    reload_c = 1'b1;
                end else if (!lock[idx_q]) begin
                    release_c = 1'b1;
                end
`else
                if (tick) begin
                    done_d    = gnt_q;
                    rx_data_d = shreg_q;
                    release_c = 1'b1;
                end
`endif
            end
            GUARD: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(GUARD_TICKS - 1)) begin
                        cnt_d       = '0;
                        presc_rst_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Locked client keeps the bus and starts its next word
        if (reload_c) begin
            shreg_d = cur_word_c;
            mosi_d  = cur_word_c[DATA_W-1];
            cnt_d   = '0;
            state_d = SETUP;
`ifdef SPI_ARB_LOCK_EN
            held_d  = 1'b0;
`endif
        end

        if (release_c) begin
            cs_n_d = '1;
            gnt_d  = '0;
            ptr_d  = next_ptr_c;
            cnt_d  = '0;
`ifdef SPI_ARB_LOCK_EN
            held_d = 1'b0;
`endif
            if (GUARD_TICKS == 0) begin
                presc_rst_d = 1'b1;
                state_d     = IDLE;
            end else begin
                state_d = GUARD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            gnt_q       <= '0;
            cs_n_q      <= '1;
            done_q      <= '0;
            rx_data_q   <= '0;
            shreg_q     <= '0;
            miso_bit_q  <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            presc_rst_q <= 1'b1;
            cnt_q       <= '0;
`ifdef SPI_ARB_LOCK_EN
            held_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            gnt_q       <= gnt_d;
            cs_n_q      <= cs_n_d;
            done_q      <= done_d;
            rx_data_q   <= rx_data_d;
            shreg_q     <= shreg_d;
            miso_bit_q  <= miso_bit_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            presc_rst_q <= presc_rst_d;
            cnt_q       <= cnt_d;
`ifdef SPI_ARB_LOCK_EN
            held_q      <= held_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rx_data   = rx_data_q;
    assign cs_n      = cs_n_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign presc_rst = presc_rst_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a divide-by-4 prescaler model and MOSI->MISO loopback.
// Lock scenario is exercised only when SPI_ARB_LOCK_EN is defined.
module tb_spi_bus_arbiter;
    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        presc_rst;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [15:0] tx_data;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [7:0]  rx_data;
    logic [1:0]  cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;

    logic        tick_force;
    logic        ptick;
    logic [1:0]  pcnt;

    int errors;
    int checks;

    spi_bus_arbiter #(
        .NUM_CLIENTS(2),
        .DATA_W     (8),
        .GUARD_TICKS(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .presc_rst(presc_rst),
        .req      (req),
        .lock     (lock),
        .tx_data  (tx_data),
        .gnt      (gnt),
        .done     (done),
        .rx_data  (rx_data),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign miso = mosi;
    assign tick = ptick | tick_force;

    // spi_prescaler model, DIVISOR=4: one enable pulse every 4 clocks out of reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt  <= 2'd0;
            ptick <= 1'b0;
        end else if (presc_rst) begin
            pcnt  <= 2'd0;
            ptick <= 1'b0;
        end else begin
            pcnt  <= pcnt + 2'd1;
            ptick <= (pcnt == 2'd3);
        end
    end

    // Bus monitor
    int         cyc;
    int         rise_cnt;
    int         gnt_events;
    int         done_events;
    int         overlap;
    int         cs1_high;
    int         last_done_cyc;
    int         min_gap;
    bit         have_done;
    logic       sclk_prev;
    logic [1:0] gnt_prev;
    logic [7:0] mon_bits;
    logic [1:0] gnt_order[$];

    initial begin
        cyc = 0; rise_cnt = 0; gnt_events = 0; done_events = 0; overlap = 0; cs1_high = 0;
        last_done_cyc = 0; min_gap = 1000000; have_done = 1'b0;
        sclk_prev = 1'b0; gnt_prev = 2'b00; mon_bits = 8'h00;
    end

    always @(negedge clk) begin
        if (sclk && !sclk_prev) begin
            rise_cnt++;
            mon_bits = {mon_bits[6:0], mosi};
        end
        sclk_prev = sclk;
        if (gnt != 2'b00 && gnt_prev == 2'b00) begin
            gnt_events++;
            gnt_order.push_back(gnt);
            if (have_done && (cyc - last_done_cyc) < min_gap) min_gap = cyc - last_done_cyc;
        end
        gnt_prev = gnt;
        if (done != 2'b00) begin
            done_events++;
            last_done_cyc = cyc;
            have_done = 1'b1;
        end
        if (!cs_n[0] && !cs_n[1]) overlap++;
        if (cs_n[1]) cs1_high++;
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt(input string tag, input logic [1:0] exp_gnt);
        int n;
        n = 0;
        while (gnt != exp_gnt && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    endtask

    task automatic wait_done(input string tag, input int who, input logic [7:0] exp_rx,
                             input logic [1:0] exp_cs);
        int         n;
        logic [1:0] exp_done;
        exp_done = 2'(1 << who);
        n = 0;
        while (done == 2'b00 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, 32'(done), 32'(exp_done));
        check_eq({tag, "_rx"}, 32'(rx_data), 32'(exp_rx));
        check_eq({tag, "_cs"}, 32'(cs_n), 32'(exp_cs));
        @(negedge clk);
        check_eq({tag, "_done_width"}, 32'(done), 32'h0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(presc_rst && gnt == 2'b00) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle"}, 32'(presc_rst), 32'h1);
    endtask

    initial begin
        int r0;
        int g0;
        int d0;
        int n;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        req = 2'b00;
        lock = 2'b00;
        tx_data = 16'h0000;
        tick_force = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_rx", 32'(rx_data), 32'h0);
        check_eq("rst_cs", 32'(cs_n), 32'h3);
        check_eq("rst_sclk", 32'(sclk), 32'h0);
        check_eq("rst_mosi", 32'(mosi), 32'h0);
        check_eq("rst_presc", 32'(presc_rst), 32'h1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ticks while idle must not move anything
        for (int i = 0; i < 3; i++) begin
            tick_force = 1'b1;
            @(negedge clk);
            tick_force = 1'b0;
            @(negedge clk);
        end
        check_eq("idle_presc", 32'(presc_rst), 32'h1);
        check_eq("idle_cs", 32'(cs_n), 32'h3);
        check_eq("idle_sclk", 32'(sclk), 32'h0);

        // Round robin with both requests held: 0,1,0
        tx_data = {8'h96, 8'h5A};
        gnt_order.delete();
        req = 2'b11;
        wait_done("rr0", 0, 8'h5A, 2'b11);
        wait_done("rr1", 1, 8'h96, 2'b11);
        wait_done("rr2", 0, 8'h5A, 2'b11);
        req = 2'b00;
        check_eq("rr_count", 32'(gnt_order.size()), 32'd3);
        if (gnt_order.size() == 3) begin
            check_eq("rr_order0", 32'(gnt_order[0]), 32'h1);
            check_eq("rr_order1", 32'(gnt_order[1]), 32'h2);
            check_eq("rr_order2", 32'(gnt_order[2]), 32'h1);
        end
        check_eq("rr_guard_gap", 32'(min_gap >= 8), 32'h1);
        wait_idle("rr");

        // Single transfer of 0xA5
        tx_data = {8'h00, 8'hA5};
        req = 2'b01;
        wait_gnt("single", 2'b01);
        check_eq("single_cs_low", 32'(cs_n), 32'h2);
        r0 = rise_cnt;
        req = 2'b00;
        wait_done("single", 0, 8'hA5, 2'b11);
        check_eq("single_sclk_pulses", 32'(rise_cnt - r0), 32'd8);
        check_eq("single_mosi_bits", 32'(mon_bits), 32'hA5);
        wait_idle("single");

        // Request dropped during bit 3 still completes, no second grant
        tx_data = {8'h00, 8'h3C};
        req = 2'b01;
        wait_gnt("drop", 2'b01);
        r0 = rise_cnt;
        n = 0;
        while ((rise_cnt - r0) < 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        req = 2'b00;
        tx_data = {8'h00, 8'hFF};
        wait_done("drop", 0, 8'h3C, 2'b11);
        g0 = gnt_events;
        repeat (150) @(negedge clk);
        check_eq("drop_no_regrant", 32'(gnt_events - g0), 32'd0);

        // Asynchronous reset during bit 5
        tx_data = {8'hC3, 8'h00};
        req = 2'b10;
        wait_gnt("rstmid", 2'b10);
        r0 = rise_cnt;
        n = 0;
        while ((rise_cnt - r0) < 5 && n < 300) begin
            @(negedge clk);
            n++;
        end
        d0 = done_events;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_cs", 32'(cs_n), 32'h3);
        check_eq("rstmid_sclk", 32'(sclk), 32'h0);
        check_eq("rstmid_gnt", 32'(gnt), 32'h0);
        check_eq("rstmid_presc", 32'(presc_rst), 32'h1);
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("rstmid_no_done", 32'(done_events - d0), 32'd0);
        tx_data = {8'h00, 8'h81};
        req = 2'b01;
        wait_gnt("fresh", 2'b01);
        req = 2'b00;
        wait_done("fresh", 0, 8'h81, 2'b11);
        check_eq("fresh_mosi_bits", 32'(mon_bits), 32'h81);
        wait_idle("fresh");

`ifdef SPI_ARB_LOCK_EN
        // Client 1 locks the bus for two words; client 0 waits
        lock = 2'b10;
        tx_data = {8'h3C, 8'h00};
        req = 2'b10;
        wait_gnt("lock", 2'b10);
        tx_data = {8'hC3, 8'h00};
        r0 = cs1_high;
        req = 2'b11;
        wait_done("lock1", 1, 8'h3C, 2'b01);
        req = 2'b01;
        wait_done("lock2", 1, 8'hC3, 2'b01);
        repeat (40) @(negedge clk);
        check_eq("lock_hold_gnt", 32'(gnt), 32'h2);
        check_eq("lock_cs1_never_high", 32'(cs1_high - r0), 32'd0);
        lock = 2'b00;
        wait_gnt("lock_rel", 2'b01);
        req = 2'b00;
        wait_done("lock_rel", 0, 8'h00, 2'b11);
`endif

        check_eq("no_cs_overlap", 32'(overlap), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
